// File: rtl/uart_tx_fifo_core.sv
// uart_tx_fifo_core: 16550-style UART transmitter with an integrated TX FIFO.
// Optional feature: define UART_TX_CTS_EN to add an active-low cts_n input that gates frame starts.
module uart_tx_fifo_core #(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        baud_pulse,
    input  logic                        s_valid,
    input  logic [7:0]                  s_data,
    output logic                        s_ready,
    input  logic [1:0]                  wls,
    input  logic                        pen,
    input  logic                        eps,
    input  logic                        stick,
    input  logic                        stb,
    input  logic                        brk,
`ifdef UART_TX_CTS_EN
    input  logic                        cts_n,
`endif
    output logic                        tx,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        tx_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(2 * OVS);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nx;
    logic [7:0]    head, head_m, sh;
    logic [2:0]    state, bit_cnt, bit_last;
    logic [CW-1:0] cnt, stop_last, bit_end;
    logic [1:0]    c_wls;
    logic          c_pen, c_stb, par, line;
    logic          push, pop, can_start, bit_done, busy_nx;

    assign push = s_valid && s_ready;
`ifdef UART_TX_CTS_EN
    assign can_start = fifo_level != '0 && !cts_n;
`else
    assign can_start = fifo_level != '0;
`endif
    assign bit_last  = {1'b1, c_wls};
    assign stop_last = !c_stb ? CW'(OVS - 1) : (c_wls == 2'd0 ? CW'(3 * OVS / 2 - 1) : CW'(2 * OVS - 1));
    assign bit_end   = state == STOP ? stop_last : CW'(OVS - 1);
    assign bit_done  = baud_pulse && cnt == bit_end;
    assign pop       = baud_pulse && can_start && (state == IDLE || (state == STOP && cnt == stop_last));
    assign busy_nx   = pop || (busy && !(state == STOP && bit_done));
    assign level_nx  = fifo_level + LW'(push) - LW'(pop);
    assign head      = mem[rd_ptr];
    assign head_m    = head & (8'hFF >> (2'd3 - wls));

    // FIFO storage; contents need no reset because the level gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= s_data;

    // FIFO pointers plus the registered level, ready and transmitter-empty flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b1;
            tx_empty   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_nx;
            s_ready    <= level_nx != LW'(FIFO_DEPTH);
            tx_empty   <= level_nx == '0 && !busy_nx;
        end
    end

    // Frame sequencer: one step per baud_pulse, frame config frozen from pop until the stop bit ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            par     <= 1'b0;
            c_wls   <= '0;
            c_pen   <= 1'b0;
            c_stb   <= 1'b0;
            line    <= 1'b1;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            tx   <= line & ~brk;
            busy <= busy_nx;
            if (pop) begin
                sh    <= head;
                par   <= stick ? ~eps : (eps ? ^head_m : ~^head_m);
                c_wls <= wls;
                c_pen <= pen;
                c_stb <= stb;
                line  <= 1'b0;
                state <= START;
                cnt   <= '0;
            end else if (baud_pulse && state != IDLE) begin
                if (!bit_done) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    case (state)
                        START: begin
                            state   <= DATA;
                            line    <= sh[0];
                            sh      <= sh >> 1;
                            bit_cnt <= '0;
                        end
                        DATA: begin
                            if (bit_cnt == bit_last) begin
                                state <= c_pen ? PARITY : STOP;
                                line  <= c_pen ? par : 1'b1;
                            end else begin
                                line    <= sh[0];
                                sh      <= sh >> 1;
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                            line  <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                            line  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule
